laser_tick_table_builder: RTL and testbench

- Parametrised successor of the laser synchroniser's tick-table update path. On a start request it drives an external CORDIC through a valid/ready theta handshake and collects the returned tick values.
- It computes per-pixel delta ticks with mirror-edge compensation, optional edge blanking and underflow saturation. It writes the results into the per-frame tick memories of the timing core.
- It sits between the memory-switch logic (start_i) and the timing core write port.

---
 rtl/laser_tick_table_builder.sv | 241 ++++++++++++++++++++++++
 tb/tb_laser_tick_table_builder.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_tick_table_builder.sv
// Rebuilds the per-frame pixel tick tables. It requests mirror-edge and point ticks from an
// external CORDIC, then writes the compensated delta ticks into the timing core's tick memories.
module laser_tick_table_builder #(
  parameter int TICK_W          = 16,
  parameter int ADDR_W          = 10,
  parameter int THETA_W         = 14,
  parameter int FSEL_W          = 4,
  parameter int FRAME_NUMBER_P  = 5,
  parameter int FRAME_COLUMNS_P = 360,
  parameter int LINE_POINTS_P   = 20
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic               start_i,
  input  logic               blank_edges_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               overrun_o,
  output logic               err_o,
  output logic               theta_valid_o,
  input  logic               theta_ready_i,
  output logic [THETA_W-1:0] theta_o,
  input  logic               tick_valid_i,
  input  logic [TICK_W-1:0]  tick_i,
  output logic               we_o,
  output logic [ADDR_W-1:0]  waddr_o,
  output logic [TICK_W:0]    wdata_o,
  output logic [FSEL_W-1:0]  frame_sel_o
);

  localparam int PASSAGES   = FRAME_COLUMNS_P / LINE_POINTS_P;
  localparam int THETA_STEP = FRAME_NUMBER_P * PASSAGES;
  localparam int TOTAL      = FRAME_COLUMNS_P * FRAME_NUMBER_P;

  localparam logic [FSEL_W-1:0] LAST_FRAME = FSEL_W'(FRAME_NUMBER_P - 1);
  localparam logic [ADDR_W-1:0] LAST_PASS  = ADDR_W'(PASSAGES - 1);
  localparam logic [ADDR_W-1:0] LAST_POINT = ADDR_W'(LINE_POINTS_P - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDGE_REQ,
    S_EDGE_WAIT,
    S_PT_REQ,
    S_PT_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [FSEL_W-1:0]  frame_q, frame_d;
  logic [ADDR_W-1:0]  pass_q, pass_d;
  logic [ADDR_W-1:0]  point_q, point_d;
  logic [TICK_W-1:0]  last_tick_q, last_tick_d;
  logic [TICK_W-1:0]  edge_q [FRAME_NUMBER_P];
  logic [TICK_W-1:0]  edge_d [FRAME_NUMBER_P];
  logic               blank_q, blank_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic               err_q, err_d;
  logic [TICK_W:0]    wdata_q, wdata_d;

  logic [THETA_W-1:0] theta_edge;
  logic [THETA_W-1:0] theta_pt;
  logic [TICK_W-1:0]  edge_sel;
  logic [TICK_W:0]    diff_w;
  logic               underflow;
  logic [TICK_W-1:0]  delta;
  logic               active;

  always_comb begin
    theta_edge = THETA_W'(TOTAL - FRAME_NUMBER_P) + THETA_W'(frame_q);
    theta_pt   = THETA_W'(point_q) * THETA_W'(THETA_STEP)
               + THETA_W'(pass_q >> 1) * THETA_W'(FRAME_NUMBER_P)
               + THETA_W'(frame_q);
  end

  // The first point of a passage is referenced to the mirror edge of its frame, not the previous point.
  always_comb begin
    edge_sel = '0;
    for (int i = 0; i < FRAME_NUMBER_P; i++) begin
      if (frame_q == FSEL_W'(i)) begin
        edge_sel = edge_q[i];
      end
    end
    diff_w    = {1'b0, tick_i} - {1'b0, last_tick_q};
    underflow = (point_q != '0) && diff_w[TICK_W];
    if (point_q != '0) begin
      delta = underflow ? '0 : diff_w[TICK_W-1:0];
    end else if (pass_q != '0) begin
      delta = tick_i + edge_sel - last_tick_q;
    end else begin
      delta = tick_i;
    end
    active = ~(blank_q & ((point_q == '0) | (point_q == LAST_POINT)));
  end

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    pass_d      = pass_q;
    point_d     = point_q;
    last_tick_d = last_tick_q;
    edge_d      = edge_q;
    blank_d     = blank_q;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    err_d       = err_q;
    wdata_d     = wdata_q;

    if (start_i && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_EDGE_REQ;
          frame_d   = '0;
          pass_d    = '0;
          point_d   = '0;
          blank_d   = blank_edges_i;
          busy_d    = 1'b1;
          overrun_d = 1'b0;
          err_d     = 1'b0;
        end
      end
      S_EDGE_REQ: begin
        if (theta_ready_i) begin
          state_d = S_EDGE_WAIT;
        end
      end
      S_EDGE_WAIT: begin
        if (tick_valid_i) begin
          for (int i = 0; i < FRAME_NUMBER_P; i++) begin
            if (frame_q == FSEL_W'(i)) begin
              edge_d[i] = tick_i;
            end
          end
          if (frame_q == LAST_FRAME) begin
            frame_d = '0;
            state_d = S_PT_REQ;
          end else begin
            frame_d = frame_q + FSEL_W'(1);
            state_d = S_EDGE_REQ;
          end
        end
      end
      S_PT_REQ: begin
        if (theta_ready_i) begin
          state_d = S_PT_WAIT;
        end
      end
      S_PT_WAIT: begin
        if (tick_valid_i) begin
          wdata_d     = {active, delta};
          last_tick_d = tick_i;
          if (underflow) begin
            err_d = 1'b1;
          end
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = S_PT_REQ;
        if (point_q == LAST_POINT) begin
          point_d = '0;
          if (pass_q == LAST_PASS) begin
            pass_d = '0;
            if (frame_q == LAST_FRAME) begin
              frame_d = '0;
              state_d = S_DONE;
            end else begin
              frame_d = frame_q + FSEL_W'(1);
            end
          end else begin
            pass_d = pass_q + ADDR_W'(1);
          end
        end else begin
          point_d = point_q + ADDR_W'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q     <= S_IDLE;
      frame_q     <= '0;
      pass_q      <= '0;
      point_q     <= '0;
      last_tick_q <= '0;
      for (int i = 0; i < FRAME_NUMBER_P; i++) begin
        edge_q[i] <= '0;
      end
      blank_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      pass_q      <= pass_d;
      point_q     <= point_d;
      last_tick_q <= last_tick_d;
      edge_q      <= edge_d;
      blank_q     <= blank_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      err_q       <= err_d;
      wdata_q     <= wdata_d;
    end
  end

  // Write-port fields are held at zero outside the write strobe so the memory side sees a quiet bus.
  always_comb begin
    busy_o        = busy_q;
    overrun_o     = overrun_q;
    err_o         = err_q;
    done_o        = (state_q == S_DONE);
    theta_valid_o = (state_q == S_EDGE_REQ) || (state_q == S_PT_REQ);
    we_o          = (state_q == S_WRITE);
    theta_o       = '0;
    if (state_q == S_EDGE_REQ) begin
      theta_o = theta_edge;
    end else if (state_q == S_PT_REQ) begin
      theta_o = theta_pt;
    end
    waddr_o     = we_o ? (pass_q * ADDR_W'(LINE_POINTS_P) + point_q) : '0;
    wdata_o     = we_o ? wdata_q : '0;
    frame_sel_o = we_o ? frame_q : '0;
  end

endmodule

// File: tb/tb_laser_tick_table_builder.sv
// Self-checking bench for laser_tick_table_builder: a CORDIC responder, a write monitor and a
// behavioural table model, driven by fixed vectors, hand-written corner sequences and random builds.
module tb_laser_tick_table_builder;

  localparam int TICK_W  = 16;
  localparam int ADDR_W  = 10;
  localparam int THETA_W = 14;
  localparam int FSEL_W  = 4;
  localparam int F       = 2;
  localparam int COLS    = 4;
  localparam int LP      = 2;
  localparam int PASS    = COLS / LP;
  localparam int STEP    = F * PASS;
  localparam int TOTAL   = COLS * F;
  localparam int NWR     = TOTAL;
  localparam int BUDGET  = 2000;

  logic               clk_i;
  logic               nrst_i;
  logic               start_i;
  logic               blank_edges_i;
  logic               busy_o;
  logic               done_o;
  logic               overrun_o;
  logic               err_o;
  logic               theta_valid_o;
  logic               theta_ready_i;
  logic [THETA_W-1:0] theta_o;
  logic               tick_valid_i;
  logic [TICK_W-1:0]  tick_i;
  logic               we_o;
  logic [ADDR_W-1:0]  waddr_o;
  logic [TICK_W:0]    wdata_o;
  logic [FSEL_W-1:0]  frame_sel_o;

  logic               resp_valid;
  logic               man_valid;
  logic [TICK_W-1:0]  resp_tick;
  logic [TICK_W-1:0]  man_tick;

  assign tick_valid_i = resp_valid | man_valid;
  assign tick_i       = man_valid ? man_tick : resp_tick;

  laser_tick_table_builder #(
    .TICK_W(TICK_W), .ADDR_W(ADDR_W), .THETA_W(THETA_W), .FSEL_W(FSEL_W),
    .FRAME_NUMBER_P(F), .FRAME_COLUMNS_P(COLS), .LINE_POINTS_P(LP)
  ) dut (
    .clk_i(clk_i), .nrst_i(nrst_i), .start_i(start_i), .blank_edges_i(blank_edges_i),
    .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o), .err_o(err_o),
    .theta_valid_o(theta_valid_o), .theta_ready_i(theta_ready_i), .theta_o(theta_o),
    .tick_valid_i(tick_valid_i), .tick_i(tick_i),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .frame_sel_o(frame_sel_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int compared   = 0;
  int mismatched = 0;

  int rsp_mode      = 0;
  int ready_mode    = 0;
  int fixed_latency = 1;
  int latency_max   = 0;
  int bad_req       = -1;
  int bad_tick      = 90;
  int hold_req      = -1;
  int hold_left     = 0;
  int hold_ok       = 0;
  int req_cnt       = 0;
  int req_theta_q[$];
  int tick_q[$];

  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_fsel_q[$];
  int neg_cnt    = 0;
  int last_we_at = -100;
  int done_at    = -50;
  logic tv_prev  = 1'b0;

  int exp_theta[$];
  int exp_addr[$];
  int exp_data[$];
  int exp_fsel[$];
  bit exp_err;

  typedef struct {
    logic             blank;
    int               bad_req;
    int               hold;
    logic [7:0][15:0] exp_delta;
    logic             exp_act;
    logic             exp_err;
  } vec_t;

  vec_t vecs[4];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] allOutputs();
    return {13'd0, busy_o, done_o, overrun_o, err_o, theta_valid_o, we_o,
            theta_o, waddr_o, wdata_o, frame_sel_o};
  endfunction

  // CORDIC stand-in: records each accepted theta and answers one tick after a configurable latency.
  initial begin : cordic_model
    int lat;
    bit pending;
    logic [TICK_W-1:0] ptick;
    pending = 0;
    lat = 0;
    ptick = '0;
    resp_valid = 1'b0;
    resp_tick = '0;
    theta_ready_i = 1'b1;
    forever begin
      @(negedge clk_i);
      resp_valid = 1'b0;
      if (!nrst_i) begin
        pending = 0;
      end else if (pending) begin
        if (lat == 0) begin
          resp_valid = 1'b1;
          resp_tick = ptick;
          pending = 0;
        end else begin
          lat--;
        end
      end
      if (theta_valid_o && req_cnt == hold_req && hold_left > 0) begin
        theta_ready_i = 1'b0;
        hold_left--;
        if (theta_o == '0) hold_ok++;
      end else if (ready_mode == 1) begin
        theta_ready_i = ($urandom_range(0, 3) != 0);
      end else begin
        theta_ready_i = 1'b1;
      end
      if (nrst_i && theta_valid_o && theta_ready_i) begin
        req_theta_q.push_back(int'(theta_o));
        if (rsp_mode == 1) ptick = TICK_W'($urandom_range(0, 65535));
        else if (req_cnt == bad_req) ptick = TICK_W'(bad_tick);
        else ptick = TICK_W'(10 * int'(theta_o) + 100);
        tick_q.push_back(int'(ptick));
        req_cnt++;
        pending = 1;
        lat = (fixed_latency >= 0) ? fixed_latency : int'($urandom_range(0, latency_max));
      end
    end
  end

  always @(posedge clk_i) tv_prev = tick_valid_i;

  initial begin : write_monitor
    forever begin
      @(negedge clk_i);
      neg_cnt++;
      if (we_o) begin
        wr_addr_q.push_back(int'(waddr_o));
        wr_data_q.push_back(int'(wdata_o));
        wr_fsel_q.push_back(int'(frame_sel_o));
        last_we_at = neg_cnt;
        checkOutput("we_one_cycle_after_tick", tv_prev, 1);
      end
      if (done_o) done_at = neg_cnt;
    end
  end

  task automatic clearQueues();
    req_theta_q.delete();
    tick_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_fsel_q.delete();
    req_cnt = 0;
  endtask

  // Expected table from the returned ticks, following the frame/passage/point loop order directly.
  task automatic buildModel(input logic blank);
    int edge_t[F];
    int idx, prev, t, d;
    bit act;
    exp_theta.delete();
    exp_addr.delete();
    exp_data.delete();
    exp_fsel.delete();
    exp_err = 0;
    for (int f = 0; f < F; f++) begin
      exp_theta.push_back(TOTAL - F + f);
      edge_t[f] = (f < tick_q.size()) ? tick_q[f] : 0;
    end
    idx = F;
    prev = 0;
    for (int f = 0; f < F; f++) begin
      for (int p = 0; p < PASS; p++) begin
        for (int l = 0; l < LP; l++) begin
          exp_theta.push_back((l * STEP + (p / 2) * F + f) % (1 << THETA_W));
          t = (idx < tick_q.size()) ? tick_q[idx] : 0;
          idx++;
          if (l > 0) begin
            if (t < prev) begin
              d = 0;
              exp_err = 1;
            end else begin
              d = t - prev;
            end
          end else if (p > 0) begin
            d = (t + edge_t[f] - prev + 65536) % 65536;
          end else begin
            d = t;
          end
          act = !(blank && (l == 0 || l == LP - 1));
          exp_addr.push_back(p * LP + l);
          exp_data.push_back((act ? 65536 : 0) + d);
          exp_fsel.push_back(f);
          prev = t;
        end
      end
    end
  endtask

  task automatic checkBuild(input logic blank);
    int n;
    buildModel(blank);
    checkOutput("theta_count", req_theta_q.size(), exp_theta.size());
    n = (req_theta_q.size() < exp_theta.size()) ? req_theta_q.size() : exp_theta.size();
    for (int i = 0; i < n; i++) checkOutput($sformatf("theta[%0d]", i), req_theta_q[i], exp_theta[i]);
    checkOutput("write_count", wr_addr_q.size(), exp_addr.size());
    n = (wr_addr_q.size() < exp_addr.size()) ? wr_addr_q.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("waddr[%0d]", i), wr_addr_q[i], exp_addr[i]);
      checkOutput($sformatf("wdata[%0d]", i), wr_data_q[i], exp_data[i]);
      checkOutput($sformatf("frame_sel[%0d]", i), wr_fsel_q[i], exp_fsel[i]);
    end
    checkOutput("err_model", err_o, exp_err);
  endtask

  task automatic applyStimulus(input logic blank, input bit start_at_done, input int inject_req);
    int cycles;
    bit injected;
    clearQueues();
    @(negedge clk_i);
    start_i = 1'b1;
    blank_edges_i = blank;
    @(negedge clk_i);
    start_i = 1'b0;
    blank_edges_i = ~blank;
    checkOutput("busy_after_start", busy_o, 1);
    checkOutput("err_cleared_by_start", err_o, 0);
    checkOutput("overrun_cleared_by_start", overrun_o, 0);
    cycles = 0;
    injected = 0;
    while (!done_o && cycles < BUDGET) begin
      @(negedge clk_i);
      cycles++;
      if (inject_req >= 0 && !injected && req_cnt > inject_req) begin
        injected = 1;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        cycles += 2;
        checkOutput("overrun_during_build", overrun_o, 1);
      end
    end
    checkOutput("done_within_budget", done_o, 1);
    checkOutput("writes_at_done", wr_addr_q.size(), NWR);
    if (start_at_done) start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    checkOutput("done_single_pulse", done_o, 0);
    checkOutput("busy_after_done", busy_o, 0);
    checkOutput("done_follows_last_write", done_at - last_we_at, 1);
    checkBuild(blank);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int cycles;
    nrst_i = 1'b0;
    start_i = 1'b0;
    blank_edges_i = 1'b0;
    man_valid = 1'b0;
    man_tick = '0;

    vecs[0].blank = 1'b0; vecs[0].bad_req = -1; vecs[0].hold = 0;
    vecs[0].exp_delta = {16'd40, 16'd130, 16'd40, 16'd110, 16'd40, 16'd120, 16'd40, 16'd100};
    vecs[0].exp_act = 1'b1; vecs[0].exp_err = 1'b0;
    vecs[1].blank = 1'b0; vecs[1].bad_req = 3; vecs[1].hold = 0;
    vecs[1].exp_delta = {16'd40, 16'd130, 16'd40, 16'd110, 16'd40, 16'd170, 16'd0, 16'd100};
    vecs[1].exp_act = 1'b1; vecs[1].exp_err = 1'b1;
    vecs[2].blank = 1'b1; vecs[2].bad_req = -1; vecs[2].hold = 0;
    vecs[2].exp_delta = vecs[0].exp_delta;
    vecs[2].exp_act = 1'b0; vecs[2].exp_err = 1'b0;
    vecs[3].blank = 1'b0; vecs[3].bad_req = -1; vecs[3].hold = 5;
    vecs[3].exp_delta = vecs[0].exp_delta;
    vecs[3].exp_act = 1'b1; vecs[3].exp_err = 1'b0;

    repeat (3) @(negedge clk_i);
    checkOutput("reset_outputs", allOutputs(), 0);
    nrst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("idle_outputs", allOutputs(), 0);

    for (int k = 0; k < 4; k++) begin
      rsp_mode = 0;
      ready_mode = 0;
      fixed_latency = 1;
      bad_req = vecs[k].bad_req;
      hold_req = (vecs[k].hold > 0) ? 2 : -1;
      hold_left = vecs[k].hold;
      hold_ok = 0;
      applyStimulus(vecs[k].blank, 0, -1);
      for (int i = 0; i < 8; i++) begin
        checkOutput($sformatf("vec%0d_wdata[%0d]", k, i),
                    (i < wr_data_q.size()) ? wr_data_q[i] : -1,
                    {vecs[k].exp_act, vecs[k].exp_delta[i]});
      end
      checkOutput($sformatf("vec%0d_err", k), err_o, vecs[k].exp_err);
      if (vecs[k].hold > 0) checkOutput("hold_valid_theta_stable", hold_ok, vecs[k].hold);
    end
    hold_req = -1;
    bad_req = -1;

    // Overrun while waiting on a point result, then a start coinciding with done.
    fixed_latency = 3;
    applyStimulus(1'b0, 0, 3);
    checkOutput("overrun_sticky_after_done", overrun_o, 1);
    fixed_latency = 1;
    applyStimulus(1'b0, 1, -1);
    checkOutput("overrun_on_start_at_done", overrun_o, 1);
    checkOutput("no_build_from_start_at_done", {busy_o, theta_valid_o}, 0);
    @(negedge clk_i);
    checkOutput("still_idle_after_done_start", {busy_o, theta_valid_o}, 0);

    // Reset while a point result is outstanding, then a stray tick after release.
    fixed_latency = 20;
    clearQueues();
    @(negedge clk_i);
    start_i = 1'b1;
    blank_edges_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    cycles = 0;
    while (req_cnt < 3 && cycles < 200) begin
      @(negedge clk_i);
      cycles++;
    end
    checkOutput("reached_point_wait", req_cnt >= 3, 1);
    @(negedge clk_i);
    nrst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("reset_mid_build_outputs", allOutputs(), 0);
    nrst_i = 1'b1;
    @(negedge clk_i);
    man_valid = 1'b1;
    man_tick = 16'h1234;
    @(negedge clk_i);
    man_valid = 1'b0;
    repeat (4) @(negedge clk_i);
    checkOutput("no_write_after_reset", wr_addr_q.size(), 0);
    checkOutput("idle_after_reset", allOutputs(), 0);

    rsp_mode = 1;
    ready_mode = 1;
    fixed_latency = -1;
    latency_max = 3;
    for (int n = 0; n < 12; n++) begin
      applyStimulus(logic'($urandom_range(0, 1)), 0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
